// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the round-robin strobe/ready memory bus arbiter.
// Holds the default bus sizes, FSM state encoding and bus direction encoding.
package mem_bus_arbiter_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STRB = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Requester after idx in round-robin order; the served one drops to lowest priority.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
// The pointer register lives in the caller.
module rr_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[IDX_W'((int'(i_ptr) + k) % NREQ)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one strobe/ready memory bus between NREQ requesters, round-robin, one transfer
// in flight. Runs the strobe/wait handshake for the winner; every output is registered.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = ADDR_SIZE,
  parameter int WORD_W  = WORD_SIZE,
  parameter int TIMEOUT = 15
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_req_rw,
  input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
  input  logic [NREQ*WORD_W-1:0]   i_req_wdata,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_done,
  output logic                     o_err,
  output logic [WORD_W-1:0]        o_rdata,
  output logic [ADDR_W-1:0]        o_bus_addr,
  output logic                     o_bus_rw,
  output logic                     o_bus_strb,
  inout  wire  [WORD_W-1:0]        io_bus_data,
  input  logic                     i_bus_rdy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              r_state, w_state;
  logic [IDX_W-1:0]    r_ptr, w_ptr;
  logic [IDX_W-1:0]    r_idx, w_idx;
  logic                r_rw, w_rw;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [WORD_W-1:0]   r_wdata, w_wdata;
  logic                r_strb, w_strb;
  logic [NREQ-1:0]     r_gnt, w_gnt;
  logic [NREQ-1:0]     r_done, w_done;
  logic                r_err, w_err;
  logic [WORD_W-1:0]   r_rdata, w_rdata;
  logic                r_drive, w_drive;
  logic [CNT_W-1:0]    r_cnt, w_cnt;

  logic [NREQ-1:0]     w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [WORD_W-1:0]   w_sel_wdata;
  logic                w_sel_rw;
  logic                w_rdy_low;
  logic                w_finish;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  assign w_sel_addr  = i_req_addr[w_pick_idx*ADDR_W +: ADDR_W];
  assign w_sel_wdata = i_req_wdata[w_pick_idx*WORD_W +: WORD_W];
  assign w_sel_rw    = i_req_rw[w_pick_idx];

  // Only a clean 0 completes; X/Z on rdy falls into the not-ready branch.
  assign w_rdy_low = (i_bus_rdy == 1'b0);

  always_comb begin
    w_state  = r_state;
    w_ptr    = r_ptr;
    w_idx    = r_idx;
    w_rw     = r_rw;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_strb   = 1'b1;
    w_gnt    = r_gnt;
    w_done   = '0;
    w_err    = 1'b0;
    w_rdata  = r_rdata;
    w_drive  = r_drive;
    w_cnt    = r_cnt;
    w_finish = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_idx   = w_pick_idx;
          w_rw    = w_sel_rw;
          w_addr  = w_sel_addr;
          w_wdata = w_sel_wdata;
          w_strb  = 1'b0;
          w_gnt   = w_pick_gnt;
          w_cnt   = '0;
          w_state = ST_STRB;
        end
      end
      ST_STRB: begin
        w_drive = (r_rw == RW_WRITE);
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_rdy_low) begin
          w_finish = 1'b1;
          if (r_rw == RW_READ) w_rdata = io_bus_data;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_finish = 1'b1;
          w_err    = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (w_finish) begin
      w_done  = r_gnt;
      w_gnt   = '0;
      w_drive = 1'b0;
      w_ptr   = IDX_W'(rr_next(int'(r_idx), NREQ));
      w_state = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_rw    <= RW_WRITE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= 1'b1;
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_drive <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_rw    <= w_rw;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_strb  <= w_strb;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rdata <= w_rdata;
      r_drive <= w_drive;
      r_cnt   <= w_cnt;
    end
  end

  assign io_bus_data = r_drive ? r_wdata : {WORD_W{1'bz}};

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_rdata    = r_rdata;
  assign o_bus_addr = r_addr;
  assign o_bus_rw   = r_rw;
  assign o_bus_strb = r_strb;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: requester agents push expected completions, a slave model answers the
// bus, and a monitor pops and checks on every done pulse and grant.
module tb_mem_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TMO = 15;

  typedef struct { bit rw; logic [7:0] addr; logic [15:0] wdata; int dly; } stim_t;
  typedef struct { bit rw; logic [7:0] addr; logic [15:0] rdata; bit err; int lat; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '0, req_rw = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0] gnt, done;
  logic err, bus_rw, bus_strb;
  logic [DW-1:0] rdata;
  logic [AW-1:0] bus_addr;
  tri   [DW-1:0] bus_data;
  logic s_rdy = 1'b1;
  logic s_drv = 1'b0;
  logic [DW-1:0] s_dout = '0;

  assign bus_data = s_drv ? s_dout : {DW{1'bz}};

  mem_bus_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .WORD_W(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_rw(req_rw), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_gnt(gnt), .o_done(done), .o_err(err), .o_rdata(rdata),
    .o_bus_addr(bus_addr), .o_bus_rw(bus_rw), .o_bus_strb(bus_strb),
    .io_bus_data(bus_data), .i_bus_rdy(s_rdy));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  logic [NREQ-1:0] req_edge = '0;
  stim_t stim_q[NREQ][$];
  exp_t  exp_q[NREQ][$];
  int cur_delay[NREQ];
  logic [15:0] smem[256];
  logic [15:0] mmem[256];
  int model_ptr = 0;
  logic [15:0] model_last = '0;
  int grant_log[$];
  bit log_on = 0;
  bit b2b_on = 0;
  int b2b_last = -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    req_edge <= req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, ~b};
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Requester agents: hold req until done, then immediately offer the next queued transfer.
  always @(negedge clk) begin
    stim_t st;
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) req[i] = 1'b0;
        if (!req[i] && stim_q[i].size() > 0) begin
          st = stim_q[i].pop_front();
          req_rw[i] = st.rw;
          req_addr[i*AW +: AW] = st.addr;
          req_wdata[i*DW +: DW] = st.wdata;
          cur_delay[i] = st.dly;
          req[i] = 1'b1;
          e.rw = st.rw;
          e.addr = st.addr;
          e.err = (st.dly >= TMO + 1);
          e.lat = e.err ? TMO + 1 : ((st.dly + 1 > 2) ? st.dly + 1 : 2);
          e.rdata = '0;
          if (st.rw) e.rdata = mmem[st.addr];
          else if (!e.err) mmem[st.addr] = st.wdata;
          exp_q[i].push_back(e);
        end
      end
    end
  end

  // Slave: rdy goes low 'delay' negedges after the strobe is seen; writes commit on done.
  logic [7:0] s_addr;
  logic s_rw, s_pend = 1'b0;
  logic [15:0] s_wcap;
  int s_cnt;
  always @(negedge clk) begin
    if (rst) begin
      s_pend = 1'b0; s_rdy = 1'b1; s_drv = 1'b0;
    end else begin
      if (s_pend && done != '0) begin
        if (!err && !s_rw && !s_rdy) smem[s_addr] = s_wcap;
        s_pend = 1'b0; s_rdy = 1'b1; s_drv = 1'b0;
      end else begin
        if (!bus_strb) begin
          s_pend = 1'b1; s_addr = bus_addr; s_rw = bus_rw;
          s_cnt = 0;
          for (int i = 0; i < NREQ; i++) if (gnt[i]) s_cnt = cur_delay[i];
        end else if (s_pend && !s_rw) begin
          s_wcap = bus_data;
        end
        if (s_pend && s_rdy) begin
          if (s_cnt == 0) begin
            s_rdy = 1'b0;
            if (s_rw) begin s_drv = 1'b1; s_dout = smem[s_addr]; end
          end else s_cnt--;
        end
      end
    end
  end

  // Monitor / scoreboard.
  logic [NREQ-1:0] prev_gnt = '0;
  int cur_owner = 0;
  int grant_cyc[NREQ];
  always @(negedge clk) begin
    bit new_g;
    exp_t e;
    if (rst) begin
      prev_gnt = '0; model_ptr = 0; model_last = '0;
    end else begin
      new_g = (gnt != '0) && (prev_gnt == '0);
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 1);
      if (!bus_strb || new_g) chk("strb_one_cycle", 32'(bus_strb), 32'(!new_g));
      if (err && done == '0) chk("err_without_done", 32'(err), 0);
      if (new_g) begin
        for (int i = 0; i < NREQ; i++) if (gnt[i]) cur_owner = i;
        chk("rr_winner", cur_owner, rr_pick(req_edge, model_ptr));
        if (log_on) grant_log.push_back(cur_owner);
        grant_cyc[cur_owner] = cyc;
        if (exp_q[cur_owner].size() == 0) chk("grant_unexpected", 1, 0);
        else begin
          chk("bus_addr", 32'(bus_addr), 32'(exp_q[cur_owner][0].addr));
          chk("bus_rw", 32'(bus_rw), 32'(exp_q[cur_owner][0].rw));
        end
      end
      if (done != '0) begin
        chk("done_owner", 32'(done), 32'(1 << cur_owner));
        chk("gnt_clear_on_done", 32'(gnt), 0);
        if (exp_q[cur_owner].size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = exp_q[cur_owner].pop_front();
          chk("err_flag", 32'(err), 32'(e.err));
          chk("latency", cyc - grant_cyc[cur_owner], e.lat);
          if (e.rw && !e.err) begin
            chk("rdata", 32'(rdata), 32'(e.rdata));
            model_last = e.rdata;
          end else chk("rdata_held", 32'(rdata), 32'(model_last));
        end
        model_ptr = (cur_owner + 1) % NREQ;
        if (b2b_on && cur_owner == 0) begin
          if (b2b_last >= 0) chk("b2b_interval", cyc - b2b_last, 3);
          b2b_last = cyc;
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic push(input int i, input bit rw, input logic [7:0] a, input logic [15:0] d,
                      input int dly);
    stim_t s;
    s.rw = rw; s.addr = a; s.wdata = d; s.dly = dly;
    stim_q[i].push_back(s);
  endtask

  task automatic drain();
    int n = 0;
    int pend;
    do begin
      pend = 0;
      for (int i = 0; i < NREQ; i++) pend += stim_q[i].size() + exp_q[i].size();
      if (pend != 0) begin @(negedge clk); n++; end
    end while (pend != 0 && n < 3000);
    if (pend != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: outstanding=%0d after %0d cycles", pend, n);
      for (int i = 0; i < NREQ; i++) begin stim_q[i].delete(); exp_q[i].delete(); end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int order[4];
    int n;
    int r;
    order = '{0, 1, 0, 1};
    for (int a = 0; a < 256; a++) begin smem[a] = init_val(a); mmem[a] = init_val(a); end
    for (int i = 0; i < NREQ; i++) begin cur_delay[i] = 0; grant_cyc[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_strb", 32'(bus_strb), 1);
    chk("rst_rw", 32'(bus_rw), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;

    // Contention straight out of reset.
    log_on = 1;
    push(0, 0, 8'h10, 16'hA000, 0); push(0, 0, 8'h12, 16'hA001, 1);
    push(1, 0, 8'h11, 16'hB000, 0); push(1, 0, 8'h13, 16'hB001, 2);
    drain();
    log_on = 0;
    chk("contention_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk("contention_order", grant_log[k], order[k]);

    // Single write then read-back from the other requester.
    push(0, 0, 8'h05, 16'h1234, 2);
    drain();
    push(1, 1, 8'h05, 16'h0000, 1);
    drain();
    chk("readback_1234", 32'(rdata), 32'h1234);

    // Timeouts and the ready/timeout boundary.
    push(0, 0, 8'h20, 16'hBEEF, 30);
    push(0, 1, 8'h05, 16'h0000, 1);
    push(0, 0, 8'h21, 16'h1111, 16);
    push(0, 0, 8'h22, 16'h2222, 15);
    push(0, 1, 8'h22, 16'h0000, 0);
    push(0, 1, 8'h21, 16'h0000, 0);
    push(0, 1, 8'h20, 16'h0000, 0);
    drain();

    // Reset in the middle of requester 1's WAIT; requester 0 is then served first.
    push(1, 0, 8'h30, 16'hC0DE, 10);
    n = 0;
    while (!gnt[1] && n < 50) begin @(negedge clk); n++; end
    if (!gnt[1]) begin total++; bad++; $display("FAIL wait_gnt1: no grant in %0d cycles", n); end
    push(0, 0, 8'h31, 16'hD00D, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_strb", 32'(bus_strb), 1);
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    grant_log.delete();
    log_on = 1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    drain();
    log_on = 0;
    chk("post_rst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    push(0, 1, 8'h30, 16'h0000, 2);
    push(1, 1, 8'h31, 16'h0000, 0);
    drain();

    // Zero-wait slave streaming from requester 0.
    b2b_last = -1;
    b2b_on = 1;
    for (int a = 0; a < 10; a++) push(0, 0, 8'(a), 16'(a), 0);
    for (int a = 0; a < 10; a++) push(0, 1, 8'(a), 16'h0000, 0);
    drain();
    b2b_on = 0;

    // Random mix; each requester owns its own address half so read results stay order-independent.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        r = int'($urandom_range(0, 9));
        push(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 127) * NREQ + i),
             16'($urandom), (r < 6) ? r % 3 : (r < 8) ? r : (r == 8) ? 15 : 16);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
